stopwatch_display: RTL and testbench
====================================

Name: stopwatch_display

Overview:
- Consumer end of the stopwatch's `minutes`/`seconds` interface.
- Converts the two 6-bit binary values into four BCD digits and drives the time-multiplexed 4-digit, active-low, common-anode 7-segment display.
- Adds a colon separator and a per-field blink for adjust mode.
- Sits between the stopwatch core and the board pins; runs on the master clock.

Parameters:
- REFRESH_DIV, 100000, master-clock cycles per digit slot; a scan tick fires on the terminal count.
- BLINK_DIV, 25000000, master-clock cycles per blink phase; the phase toggles on the terminal count.

Ports:
- clk  input  1  master clock
- rst  input  1  reset, synchronous, active-low (rst==0 resets on the next posedge clk)
- minutes  input  6  binary minutes from the stopwatch core
- seconds  input  6  binary seconds from the stopwatch core
- blink_sel  input  2  00 none, 01 blink seconds, 10 blink minutes, 11 blink both
- an  output  4  digit enables, active-low; an[0] is the rightmost digit
- seg  output  7  {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low

Behaviour:
- Reset (rst==0 at posedge) sets:
  - an=4'b1111, seg=7'b1111111, dp=1
  - refresh_cnt=0, blink_cnt=0, blink_phase=1 (visible)
  - digit_idx=3, snapshot min/sec=0
- Reset mid-operation takes effect immediately on that edge. Outputs stay blank until the first scan tick after rst returns to 1.
- refresh_cnt counts 0..REFRESH_DIV-1 and wraps; tick=1 for exactly one cycle when refresh_cnt==REFRESH_DIV-1.
- On a tick edge: digit_idx <= digit_idx+1 mod 4.
  - On the 3->0 wrap, minutes/seconds are captured into the snapshot (frame-coherent, no tearing).
  - an/seg/dp are registered on the same edge from the new digit_idx and the new snapshot.
  - Outputs are constant between ticks.
- Digit map:
  - idx0 = seconds ones (an=1110)
  - idx1 = seconds tens (an=1101)
  - idx2 = minutes ones (an=1011)
  - idx3 = minutes tens (an=0111)
- dp=0 only while idx2 is active (colon); otherwise dp=1.
- BCD conversion: tens = value/10, ones = value%10, valid for 0..59.
- A field with value > 59 shows dash on both of its digits (seg=7'b0111111); the other field is unaffected.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Blink:
  - blink_cnt runs continuously from reset; blink_phase toggles when blink_cnt==BLINK_DIV-1.
  - When blink_phase==0 and the active digit belongs to a selected field, an=4'b1111 for that slot. Scan timing is unchanged, and seg/dp still carry the normal code.
  - blink_sel is sampled at each tick edge only.
- Simultaneous events: a tick coinciding with a blink toggle uses the post-toggle phase. The snapshot ignores input changes outside the wrap edge.

Decomposition:
- Shared package:
  - segment code constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK
  - digit index constants DIG_SEC_ONES..DIG_MIN_TENS
  - blink_sel encodings
- One sub-module, seg7_encode: combinational 4-bit BCD (plus dash flag) to 7-bit active-low segments.
- Counters, snapshot, BCD split and blink logic live in stopwatch_display.

Test Plan (REFRESH_DIV=4, BLINK_DIV=32):
- Reset: hold rst=0 for 3 cycles, then release -> an=1111, seg=1111111, dp=1 through cycle 3 after release. First tick: an=1110.
- Value 12:34:
  - ticks 1..4 give an=1110/seg=0011001, an=1101/0110000, an=1011/0100100 with dp=0, an=0111/1111001.
  - Sequence repeats every 16 cycles.
- Snapshot coherence: load 00:00, then change seconds to 59 while idx1 is active -> idx1 still shows 1000000. New value appears only after the next 3->0 wrap (idx0=0010000, idx1=0010010).
- Boundary: minutes=60, seconds=59 -> idx2/idx3 seg=0111111, idx0=0010000, idx1=0010010. minutes=0, seconds=0 -> all four digits 1000000.
- Blink: blink_sel=01 with 12:34 -> during a phase-0 window of 32 cycles, idx0/idx1 slots drive an=1111 and idx2/idx3 are normal. blink_sel=00 -> no blanking.
- Reset mid-frame: assert rst=0 while idx2 is active -> next edge gives an=1111, dp=1, digit_idx=3. After release the scan restarts at idx0 after 4 cycles.

Source files
------------

// File: rtl/stopwatch_display_pkg.sv
// Shared constants for the stopwatch display path.
//   - Active-low 7-segment codes, {g,f,e,d,c,b,a} bit order
//   - Digit slot indices; slot 0 is the rightmost digit (an[0])
//   - blink_sel encodings
package stopwatch_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    localparam logic [1:0] BLINK_NONE = 2'b00;
    localparam logic [1:0] BLINK_SEC  = 2'b01;
    localparam logic [1:0] BLINK_MIN  = 2'b10;
    localparam logic [1:0] BLINK_BOTH = 2'b11;

    // Largest value a minutes/seconds field may hold before it is shown as dashes.
    localparam logic [5:0] FIELD_MAX = 6'd59;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to active-low 7-segment code.
//   bcd  : BCD digit 0..9 (codes 10..15 render blank)
//   dash : overrides the digit with a centre-bar dash
//   seg  : {g,f,e,d,c,b,a}, active-low
module seg7_encode
    import stopwatch_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/stopwatch_display.sv
// Time-multiplexed MM:SS driver for a 4-digit common-anode 7-segment display.
//   clk       : master clock
//   rst       : synchronous reset, active-low
//   minutes   : binary minutes from the stopwatch core (>59 shows dashes)
//   seconds   : binary seconds from the stopwatch core (>59 shows dashes)
//   blink_sel : 00 none, 01 seconds, 10 minutes, 11 both
//   an        : digit enables, active-low, an[0] rightmost
//   seg       : {g,f,e,d,c,b,a}, active-low
//   dp        : decimal point (colon), active-low, lit on the minutes-ones slot
module stopwatch_display
    import stopwatch_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic [1:0] blink_sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [RW-1:0] refresh_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [1:0]    digit_idx;
    logic [5:0]    snap_min;
    logic [5:0]    snap_sec;

    logic          tick;
    logic          blink_toggle;
    logic          phase_next;
    logic [1:0]    idx_next;
    logic          frame_wrap;
    logic [5:0]    min_next;
    logic [5:0]    sec_next;
    logic          field_is_min;
    logic [5:0]    field_val;
    logic          field_dash;
    logic [3:0]    digit_bcd;
    logic          field_selected;
    logic          slot_blank;
    logic [3:0]    an_base;
    logic [6:0]    seg_code;

    // Everything below is evaluated for the slot being entered on the next tick,
    // so the registered outputs use the new index, new snapshot and new phase.
    always_comb begin
        tick         = (refresh_cnt == REFRESH_LAST);
        blink_toggle = (blink_cnt == BLINK_LAST);
        phase_next   = blink_toggle ? ~blink_phase : blink_phase;
        idx_next     = digit_idx + 2'd1;
        // Capturing only on the 3->0 wrap keeps all four digits of one frame coherent.
        frame_wrap   = (idx_next == DIG_SEC_ONES);
        min_next     = frame_wrap ? minutes : snap_min;
        sec_next     = frame_wrap ? seconds : snap_sec;

        field_is_min = idx_next[1];
        field_val    = field_is_min ? min_next : sec_next;
        field_dash   = (field_val > FIELD_MAX);
        digit_bcd    = idx_next[0] ? 4'(field_val / 6'd10) : 4'(field_val % 6'd10);

        field_selected = field_is_min ? blink_sel[1] : blink_sel[0];
        slot_blank     = ~phase_next & field_selected;

        an_base = 4'b1111;
        case (idx_next)
            DIG_SEC_ONES: an_base = 4'b1110;
            DIG_SEC_TENS: an_base = 4'b1101;
            DIG_MIN_ONES: an_base = 4'b1011;
            DIG_MIN_TENS: an_base = 4'b0111;
            default:      an_base = 4'b1111;
        endcase
    end

    seg7_encode u_seg7_encode (
        .bcd  (digit_bcd),
        .dash (field_dash),
        .seg  (seg_code)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            digit_idx   <= DIG_MIN_TENS;
            snap_min    <= '0;
            snap_sec    <= '0;
            an          <= 4'b1111;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
        end else begin
            refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;
            blink_cnt   <= blink_toggle ? '0 : blink_cnt + 1'b1;
            blink_phase <= phase_next;
            if (tick) begin
                digit_idx <= idx_next;
                snap_min  <= min_next;
                snap_sec  <= sec_next;
                // Blanking only gates the anode; seg/dp keep the normal code.
                an        <= slot_blank ? 4'b1111 : an_base;
                seg       <= seg_code;
                dp        <= (idx_next == DIG_MIN_ONES) ? 1'b0 : 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
module tb_stopwatch_display;

    localparam int RD = 4;
    localparam int BD = 32;
    localparam int NF = 9;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    typedef struct {
        logic [5:0] min;
        logic [5:0] sec;
        logic [1:0] sel;
        logic [6:0] s0;
        logic [6:0] s1;
        logic [6:0] s2;
        logic [6:0] s3;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] blink_sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    vec_t vecs [NF];
    exp_t sb [$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    stopwatch_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk       (clk),
        .rst       (rst),
        .minutes   (minutes),
        .seconds   (seconds),
        .blink_sel (blink_sel),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] base_an(int slot);
        case (slot)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // Expected outputs for all four slots of frame f. Tick k lands on edge 4k
    // after release; the blink phase is 0 on edges where (edge/32) is odd.
    task automatic push_frame(int f);
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            int  tk;
            int  ed;
            logic ph0;
            logic selbit;
            tk     = 4 * f + s + 1;
            ed     = RD * tk;
            ph0    = ((ed / BD) % 2) == 1;
            selbit = (s >= 2) ? vecs[f].sel[1] : vecs[f].sel[0];
            e.an   = (ph0 && selbit) ? 4'b1111 : base_an(s);
            case (s)
                0:       e.seg = vecs[f].s0;
                1:       e.seg = vecs[f].s1;
                2:       e.seg = vecs[f].s2;
                default: e.seg = vecs[f].s3;
            endcase
            e.dp = (s == 2) ? 1'b0 : 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic check_out(string name, logic [3:0] ea, logic [6:0] es, logic edp);
        checks++;
        if (an !== ea || seg !== es || dp !== edp) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, an, seg, dp, ea, es, edp);
        end
    endtask

    initial begin
        int e;
        int t;
        int slot;
        int f;

        vecs[0] = '{6'd12, 6'd34, 2'b00, S4, S3, S2, S1};
        vecs[1] = '{6'd12, 6'd34, 2'b01, S4, S3, S2, S1};
        vecs[2] = '{6'd12, 6'd34, 2'b01, S4, S3, S2, S1};
        vecs[3] = '{6'd12, 6'd34, 2'b00, S4, S3, S2, S1};
        vecs[4] = '{6'd0,  6'd0,  2'b11, S0, S0, S0, S0};
        vecs[5] = '{6'd0,  6'd59, 2'b00, S9, S5, S0, S0};
        vecs[6] = '{6'd60, 6'd59, 2'b10, S9, S5, SD, SD};
        vecs[7] = '{6'd59, 6'd60, 2'b00, SD, SD, S9, S5};
        vecs[8] = '{6'd63, 6'd0,  2'b11, S0, S0, SD, SD};

        rst       = 1'b0;
        minutes   = vecs[0].min;
        seconds   = vecs[0].sec;
        blink_sel = vecs[0].sel;
        push_frame(0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_out("reset_hold", 4'b1111, SB, 1'b1);
        rst = 1'b1;

        cur = '{an: 4'b1111, seg: SB, dp: 1'b1};
        e = 0;
        // Inputs for frame f+1 change while slot 0 of frame f is lit, so the
        // remaining slots of frame f also check that the snapshot does not tear.
        while (e < NF * 4 * RD) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (e % RD != 0) begin
                check_out("hold_between_ticks", cur.an, cur.seg, cur.dp);
            end else begin
                t    = e / RD;
                slot = (t - 1) % 4;
                f    = (t - 1) / 4;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: tick %0d had no expected entry", t);
                end else begin
                    cur = sb.pop_front();
                    check_out($sformatf("frame%0d_slot%0d", f, slot), cur.an, cur.seg, cur.dp);
                end
                if (slot == 0 && f + 1 < NF) begin
                    minutes = vecs[f + 1].min;
                    seconds = vecs[f + 1].sec;
                    push_frame(f + 1);
                end
                if (slot == 3 && f + 1 < NF) blink_sel = vecs[f + 1].sel;
            end
        end

        // Run to the minutes-ones slot (edge 156, blink phase 1), then reset mid-frame.
        repeat (3 * RD) @(posedge clk);
        @(negedge clk);
        check_out("pre_reset_idx2", 4'b1011, SD, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_out("midframe_reset", 4'b1111, SB, 1'b1);
        rst = 1'b1;
        for (int k = 1; k < RD; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_out($sformatf("post_reset_blank%0d", k), 4'b1111, SB, 1'b1);
        end
        @(posedge clk);
        @(negedge clk);
        check_out("post_reset_first_tick", 4'b1110, S0, 1'b1);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
